// File: rtl/cart_bus_sequencer.sv
// Cartridge-bus sequencer: turns one decoded CPU access plus the mapper's resolved outputs into a
// memory req/ack transaction, a mapper register read, or an open-bus return, and keeps the open-bus latch.
module cart_bus_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int ADDR_W  = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              cart_sel,
    input  logic              prg_read,
    input  logic              prg_write,
    input  logic [15:0]       prg_ain,
    input  logic [7:0]        cpu_wdata,
    input  logic [ADDR_W-1:0] prg_aout,
    input  logic              prg_allow,
    input  logic [7:0]        prg_dout,
    input  logic [15:0]       flags_out,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rvalid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        open_bus,
    output logic              timeout_err,
    output logic              drop_err,
    output logic [2:0]        o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CRD  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_cnt;
    logic              r_hold;
    logic              r_is_rd;
    logic [7:0]        r_wdata;
    logic [7:0]        r_rdata;
    logic [7:0]        r_open_bus;
    logic [7:0]        r_mem_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic              r_timeout_err;
    logic              r_drop_err;
    logic              w_access;
    logic              w_start;
    logic              w_req;
    logic              w_timeout;
    logic              w_unused;

    // Handshake: mem_req is a pure function of the state register and stays high until the cycle
    // mem_ack is sampled with it; address/we/wdata only change on that accepting edge.
    assign w_access  = cart_sel & (prg_read | prg_write);
    assign w_start   = ce & w_access & (r_state == S_IDLE);
    assign w_req     = (r_state == S_RD) | (r_state == S_CRD) | (r_state == S_WR);
    assign w_timeout = w_req & ~mem_ack & (r_cnt == 8'(TIMEOUT - 1));
    assign w_unused  = ^{prg_ain[14:0], flags_out[15:3], flags_out[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (prg_read) begin
                        if (flags_out[1])   w_next = S_DONE;
                        else if (prg_allow) w_next = S_RD;
                        else                w_next = S_DONE;
                    end else begin
                        if (flags_out[1])                                  w_next = S_DONE;
                        else if (prg_allow && flags_out[2] && prg_ain[15]) w_next = S_CRD;
                        else if (prg_allow)                                w_next = S_WR;
                        else                                               w_next = S_DONE;
                    end
                end
            end
            S_RD:    if (mem_ack || w_timeout) w_next = S_DONE;
            S_CRD: begin
                if (mem_ack)        w_next = S_WR;
                else if (w_timeout) w_next = S_DONE;
            end
            S_WR:    if (mem_ack || w_timeout) w_next = S_DONE;
            S_DONE:  if (!r_hold) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        cpu_rvalid = 1'b0;
        case (r_state)
            S_RD, S_CRD, S_WR: mem_req = 1'b1;
            S_DONE:            cpu_rvalid = ~r_hold;
            default:           ;
        endcase
    end

    // Direct (no memory) accesses spend an extra hold cycle in DONE so that their completion
    // lands two cycles after ce, the same as a memory access acked in its first request cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            r_hold        <= 1'b0;
            r_is_rd       <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_open_bus    <= '0;
            r_mem_wdata   <= '0;
            r_mem_addr    <= '0;
            r_mem_we      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_drop_err    <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            r_drop_err    <= ce & w_access & (r_state != S_IDLE);

            if (w_req && !(r_state == S_CRD && mem_ack)) r_cnt <= r_cnt + 8'd1;
            else                                         r_cnt <= '0;

            if (w_start) begin
                r_is_rd <= prg_read;
                r_wdata <= cpu_wdata;
                r_hold  <= (w_next == S_DONE);
                if (prg_read) begin
                    if (flags_out[1])    r_rdata <= prg_dout;
                    else if (!prg_allow) r_rdata <= r_open_bus;
                end
                if (w_next != S_DONE) begin
                    r_mem_addr <= prg_aout;
                    r_mem_we   <= (w_next == S_WR);
                    if (w_next == S_WR) r_mem_wdata <= cpu_wdata;
                end
            end

            if (r_state == S_RD) begin
                if (mem_ack)        r_rdata <= mem_rdata;
                else if (w_timeout) r_rdata <= r_open_bus;
            end

            // Bus conflict: the ROM drives the bus too, so the stored byte is the AND of both.
            if (r_state == S_CRD && mem_ack) begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= r_wdata & mem_rdata;
                r_wdata     <= r_wdata & mem_rdata;
            end

            if (r_state == S_DONE) begin
                r_hold <= 1'b0;
                if (!r_hold) r_open_bus <= r_is_rd ? r_rdata : r_wdata;
            end
        end
    end

    assign cpu_rdata   = r_rdata;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign open_bus    = r_open_bus;
    assign timeout_err = r_timeout_err;
    assign drop_err    = r_drop_err;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_cart_bus_sequencer.sv
// Bench for cart_bus_sequencer: a per-access timeline model predicts every cycle's outputs,
// a negedge compare process checks them, and literal checks pin the documented examples.
module tb_cart_bus_sequencer;
    localparam int TIMEOUT = 15;
    localparam int ADDR_W  = 22;
    localparam int NC      = 1024;
    localparam int NEVER   = 999;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ce = 1'b0;
    logic              cart_sel = 1'b0;
    logic              prg_read = 1'b0;
    logic              prg_write = 1'b0;
    logic [15:0]       prg_ain = '0;
    logic [7:0]        cpu_wdata = '0;
    logic [ADDR_W-1:0] prg_aout = '0;
    logic              prg_allow = 1'b0;
    logic [7:0]        prg_dout = '0;
    logic [15:0]       flags_out = '0;
    logic [7:0]        cpu_rdata;
    logic              cpu_rvalid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack = 1'b0;
    logic [7:0]        mem_rdata = 8'hEE;
    logic [7:0]        open_bus;
    logic              timeout_err;
    logic              drop_err;
    logic [2:0]        dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rv_cyc = 0;
    bit chk_en = 1'b0;

    // Expected timeline, indexed by absolute cycle number
    bit          e_req[NC];
    bit          e_we[NC];
    logic [21:0] e_addr[NC];
    logic [7:0]  e_wd[NC];
    bit          e_wdchk[NC];
    bit          e_rv[NC];
    logic [7:0]  e_rd[NC];
    bit          e_rdchk[NC];
    bit          e_terr[NC];
    bit          e_derr[NC];
    bit          ob_set[NC];
    logic [7:0]  ob_val[NC];
    bit          ack_s[NC];
    logic [7:0]  rdat_s[NC];
    logic [7:0]  cur_ob = 8'h00;
    logic [7:0]  m_ob = 8'h00;
    int          m_idle_at = 0;

    cart_bus_sequencer #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .ce(ce), .cart_sel(cart_sel),
        .prg_read(prg_read), .prg_write(prg_write), .prg_ain(prg_ain),
        .cpu_wdata(cpu_wdata), .prg_aout(prg_aout), .prg_allow(prg_allow),
        .prg_dout(prg_dout), .flags_out(flags_out), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .open_bus(open_bus), .timeout_err(timeout_err),
        .drop_err(drop_err), .o_dbg_state(dbg_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder replays the scheduled acks
    always @(posedge clk) begin
        #1;
        mem_ack   = (cyc < NC) ? ack_s[cyc] : 1'b0;
        mem_rdata = ((cyc < NC) && ack_s[cyc]) ? rdat_s[cyc] : 8'hEE;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard compare process
    always @(negedge clk) begin
        if (cyc < NC) begin
            if (ob_set[cyc]) cur_ob = ob_val[cyc];
            if (cpu_rvalid) last_rv_cyc = cyc;
            if (chk_en && !reset) begin
                chk("mem_req", 32'(mem_req), 32'(e_req[cyc]));
                if (e_req[cyc]) begin
                    chk("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
                    chk("mem_we", 32'(mem_we), 32'(e_we[cyc]));
                    if (e_wdchk[cyc]) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd[cyc]));
                end
                chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_rv[cyc]));
                if (e_rv[cyc] && e_rdchk[cyc]) chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rd[cyc]));
                chk("timeout_err", 32'(timeout_err), 32'(e_terr[cyc]));
                chk("drop_err", 32'(drop_err), 32'(e_derr[cyc]));
                chk("open_bus", 32'(open_bus), 32'(cur_ob));
            end
        end
    end

    // Model helpers: a request phase, an ack, and the completion of an access
    task automatic span(input int s, input int n, input bit we, input logic [21:0] a,
                        input logic [7:0] wd, input bit wchk);
        for (int i = s; i < s + n; i++) begin
            e_req[i] = 1'b1; e_we[i] = we; e_addr[i] = a; e_wd[i] = wd; e_wdchk[i] = wchk;
        end
    endtask

    task automatic sched_ack(input int t, input logic [7:0] d);
        ack_s[t] = 1'b1;
        rdat_s[t] = d;
    endtask

    task automatic sched_done(input int rv, input bit is_rd, input logic [7:0] d);
        e_rv[rv] = 1'b1; e_rd[rv] = d; e_rdchk[rv] = is_rd;
        ob_set[rv + 1] = 1'b1; ob_val[rv + 1] = d;
        m_ob = d;
        m_idle_at = rv + 1;
    endtask

    // Behavioural model: what one ce in cycle c must produce
    task automatic model(input int c, input bit sel, input bit rd, input bit wr,
                         input logic [15:0] ain, input logic [7:0] wd, input logic [21:0] aout,
                         input bit allow, input logic [7:0] dout, input logic [15:0] flags,
                         input int d1, input int d2, input logic [7:0] rom);
        if (!sel || !(rd || wr)) return;
        if (c < m_idle_at) begin
            e_derr[c + 1] = 1'b1;
            return;
        end
        if (rd) begin
            if (flags[1]) sched_done(c + 2, 1'b1, dout);
            else if (allow) begin
                if (d1 <= TIMEOUT) begin
                    span(c + 1, d1, 1'b0, aout, 8'h00, 1'b0);
                    sched_ack(c + d1, rom);
                    sched_done(c + d1 + 1, 1'b1, rom);
                end else begin
                    span(c + 1, TIMEOUT, 1'b0, aout, 8'h00, 1'b0);
                    e_terr[c + TIMEOUT + 1] = 1'b1;
                    sched_done(c + TIMEOUT + 1, 1'b1, m_ob);
                end
            end else sched_done(c + 2, 1'b1, m_ob);
        end else begin
            if (flags[1] || !allow) sched_done(c + 2, 1'b0, wd);
            else if (flags[2] && ain[15]) begin
                span(c + 1, d1, 1'b0, aout, 8'h00, 1'b0);
                sched_ack(c + d1, rom);
                span(c + d1 + 1, d2, 1'b1, aout, wd & rom, 1'b1);
                sched_ack(c + d1 + d2, 8'hEE);
                sched_done(c + d1 + d2 + 1, 1'b0, wd & rom);
            end else if (d1 <= TIMEOUT) begin
                span(c + 1, d1, 1'b1, aout, wd, 1'b1);
                sched_ack(c + d1, 8'hEE);
                sched_done(c + d1 + 1, 1'b0, wd);
            end else begin
                span(c + 1, TIMEOUT, 1'b1, aout, wd, 1'b1);
                e_terr[c + TIMEOUT + 1] = 1'b1;
                sched_done(c + TIMEOUT + 1, 1'b0, wd);
            end
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic access(input bit sel, input bit rd, input bit wr, input logic [15:0] ain,
                          input logic [7:0] wd, input logic [21:0] aout, input bit allow,
                          input logic [7:0] dout, input logic [15:0] flags,
                          input int d1, input int d2, input logic [7:0] rom);
        model(cyc, sel, rd, wr, ain, wd, aout, allow, dout, flags, d1, d2, rom);
        ce = 1'b1; cart_sel = sel; prg_read = rd; prg_write = wr; prg_ain = ain;
        cpu_wdata = wd; prg_aout = aout; prg_allow = allow; prg_dout = dout; flags_out = flags;
        tick();
        ce = 1'b0; cart_sel = 1'b0; prg_read = 1'b0; prg_write = 1'b0; prg_ain = 16'h0000;
        cpu_wdata = 8'hFF; prg_aout = 22'h3FFFFF; prg_allow = 1'b0; prg_dout = 8'hA5; flags_out = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd0);
        chk({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_open_bus"}, 32'(open_bus), 32'd0);
        chk({tag, "_errs"}, 32'({timeout_err, drop_err}), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    int c0;

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        chk_en = 1'b1;

        // Mapper register read
        c0 = cyc;
        access(1, 1, 0, 16'h4100, 8'h00, 22'h000000, 0, 8'h3A, 16'h0002, 0, 0, 8'h00);
        wait_until(m_idle_at);
        chk("lit_direct_rdata", 32'(cpu_rdata), 32'h3A);
        chk("lit_direct_ob", 32'(open_bus), 32'h3A);
        chk("lit_direct_latency", 32'(last_rv_cyc - c0), 32'd2);

        // ROM read, ack in third request cycle
        c0 = cyc;
        access(1, 1, 0, 16'h8000, 8'h00, 22'h004000, 1, 8'h00, 16'h0000, 3, 0, 8'hC5);
        wait_until(m_idle_at);
        chk("lit_rd_rdata", 32'(cpu_rdata), 32'hC5);
        chk("lit_rd_addr", 32'(mem_addr), 32'h004000);
        chk("lit_rd_latency", 32'(last_rv_cyc - c0), 32'd4);

        // Bus-conflict write
        access(1, 0, 1, 16'h8000, 8'hF3, 22'h004000, 1, 8'h00, 16'h0004, 2, 2, 8'h5C);
        wait_until(m_idle_at);
        chk("lit_conf_wdata", 32'(mem_wdata), 32'h50);
        chk("lit_conf_ob", 32'(open_bus), 32'h50);

        // Read timeout returns previous open bus
        access(1, 1, 0, 16'h9000, 8'h00, 22'h001000, 1, 8'h00, 16'h0000, NEVER, 0, 8'h00);
        wait_until(m_idle_at);
        chk("lit_to_rdata", 32'(cpu_rdata), 32'h50);

        // Second ce during a pending read is dropped
        access(1, 1, 0, 16'h8123, 8'h00, 22'h001234, 1, 8'h00, 16'h0000, 6, 0, 8'h6E);
        tick();
        access(1, 1, 0, 16'h4100, 8'h00, 22'h3F0000, 1, 8'h99, 16'h0002, 0, 0, 8'h00);
        wait_until(m_idle_at);
        chk("lit_drop_rdata", 32'(cpu_rdata), 32'h6E);

        // Ack in first request cycle, ack on the last allowed cycle, open-bus read
        access(1, 1, 0, 16'hA000, 8'h00, 22'h020000, 1, 8'h00, 16'h0000, 1, 0, 8'h11);
        wait_until(m_idle_at);
        access(1, 1, 0, 16'hA001, 8'h00, 22'h020001, 1, 8'h00, 16'h0000, TIMEOUT, 0, 8'h22);
        wait_until(m_idle_at);
        access(1, 1, 0, 16'h5000, 8'h00, 22'h000000, 0, 8'h00, 16'h0000, 0, 0, 8'h00);
        wait_until(m_idle_at);

        // Writes: conflict flag below $8000, mapper register write, disallowed write
        access(1, 0, 1, 16'h6000, 8'h77, 22'h300000, 1, 8'h00, 16'h0004, 4, 0, 8'h00);
        wait_until(m_idle_at);
        access(1, 0, 1, 16'h8000, 8'h99, 22'h000000, 1, 8'h00, 16'h0002, 0, 0, 8'h00);
        wait_until(m_idle_at);
        access(1, 0, 1, 16'h4800, 8'h5A, 22'h000000, 0, 8'h00, 16'h0000, 0, 0, 8'h00);
        wait_until(m_idle_at);

        // Ignored strobes
        access(0, 1, 0, 16'h2002, 8'h00, 22'h000000, 1, 8'h00, 16'h0000, 1, 0, 8'h00);
        access(1, 0, 0, 16'h8000, 8'h00, 22'h000000, 1, 8'h00, 16'h0000, 1, 0, 8'h00);
        repeat (3) tick();
        chk("lit_ignored_rdata", 32'(cpu_rdata), 32'h22);
        chk("lit_ignored_ob", 32'(open_bus), 32'h5A);

        // ce in the DONE cycle is dropped
        access(1, 1, 0, 16'h4100, 8'h00, 22'h000000, 0, 8'h42, 16'h0002, 0, 0, 8'h00);
        tick();
        access(1, 1, 0, 16'h4101, 8'h00, 22'h000000, 0, 8'h24, 16'h0002, 0, 0, 8'h00);
        wait_until(m_idle_at + 1);
        chk("lit_done_drop_rdata", 32'(cpu_rdata), 32'h42);

        // Write timeout is abandoned but still completes
        access(1, 0, 1, 16'h8000, 8'h66, 22'h010000, 1, 8'h00, 16'h0000, NEVER, 0, 8'h00);
        wait_until(m_idle_at);
        chk("lit_wto_ob", 32'(open_bus), 32'h66);

        // Reset in the middle of a write
        c0 = cyc;
        access(1, 0, 1, 16'h8000, 8'h3C, 22'h012345, 1, 8'h00, 16'h0000, NEVER, 0, 8'h00);
        wait_until(c0 + 4);
        chk("lit_wr_req_before_reset", 32'(mem_req), 32'd1);
        #2;
        chk_en = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        for (int i = cyc; i < NC; i++) begin
            e_req[i] = 1'b0; e_rv[i] = 1'b0; e_terr[i] = 1'b0; e_derr[i] = 1'b0;
            ob_set[i] = 1'b0; ack_s[i] = 1'b0;
        end
        m_ob = 8'h00;
        cur_ob = 8'h00;
        m_idle_at = 0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_en = 1'b1;

        // Normal access after reset release
        access(1, 1, 0, 16'h4100, 8'h00, 22'h000000, 0, 8'h81, 16'h0002, 0, 0, 8'h00);
        wait_until(m_idle_at);
        chk("lit_post_reset_ob", 32'(open_bus), 32'h81);
        access(1, 1, 0, 16'h8000, 8'h00, 22'h004000, 1, 8'h00, 16'h0000, 2, 0, 8'hB7);
        wait_until(m_idle_at + 2);
        chk("lit_post_reset_rd", 32'(cpu_rdata), 32'hB7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
